// File: rtl/vram_port_arbiter_pkg.sv
// vram_arb_pkg: shared types for the VRAM port-A arbiter.
//   arb_state_t : arbiter FSM states (IDLE, CPU read data cycle, engine read data cycle)
//   gnt_t       : identity of a granted requester (also the last_gnt encoding)
//   PAL_SEL_BIT : Avalon word-address bit selecting the palette region
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        ENG_RD = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_ENG = 1'b1
    } gnt_t;

    localparam int unsigned PAL_SEL_BIT = 11;

endpackage

// File: rtl/vram_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker with its own last-grant register.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   en_i          : grant decisions allowed this cycle
//   req_cpu_i     : CPU-side request
//   req_eng_i     : engine-side request
//   gnt_vld_o     : a grant is issued this cycle (combinational)
//   gnt_o         : which side is granted (valid only with gnt_vld_o)
// last_gnt resets to GNT_ENG so the CPU wins the first contention.
module rr_arb2
    import vram_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_cpu_i,
    input  logic req_eng_i,
    output logic gnt_vld_o,
    output gnt_t gnt_o
);

    gnt_t last_gnt_q;
    gnt_t last_gnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt_q <= GNT_ENG;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        gnt_o      = GNT_CPU;
        gnt_vld_o  = 1'b0;
        last_gnt_d = last_gnt_q;
        if (en_i) begin
            if (req_cpu_i && req_eng_i) begin
                // Contention: the side that did not win last time goes now.
                gnt_o     = (last_gnt_q == GNT_ENG) ? GNT_CPU : GNT_ENG;
                gnt_vld_o = 1'b1;
            end else if (req_cpu_i) begin
                gnt_o     = GNT_CPU;
                gnt_vld_o = 1'b1;
            end else if (req_eng_i) begin
                gnt_o     = GNT_ENG;
                gnt_vld_o = 1'b1;
            end
        end
        if (gnt_vld_o) begin
            last_gnt_d = gnt_o;
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares VRAM RAM port A between the Avalon-MM slave and a
// game-engine requester, round-robin, one transaction per grant. Port B is
// not touched here. Palette-region Avalon accesses (AVL_ADDR[11]=1) complete
// immediately without touching the RAM.
//   CLK, RESET         : clock, asynchronous active-high reset
//   AVL_*              : Avalon-MM slave (word address, bit 11 = palette)
//   ENG_REQ/WE/ADDR/BYTE_EN/WDATA : engine request, held until ENG_GNT
//   ENG_GNT            : one-cycle accept pulse
//   ENG_RVALID/RDATA   : registered engine read return
//   RAM_*              : port A controls, combinational from the grant; RAM_Q
//                        is valid the cycle after RAM_RDEN
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   AVL_CS,
    input  logic                   AVL_READ,
    input  logic                   AVL_WRITE,
    input  logic [PAL_SEL_BIT:0]   AVL_ADDR,
    input  logic [BE_W-1:0]        AVL_BYTE_EN,
    input  logic [DATA_W-1:0]      AVL_WRITEDATA,
    output logic [DATA_W-1:0]      AVL_READDATA,
    output logic                   AVL_WAITREQUEST,
    input  logic                   ENG_REQ,
    input  logic                   ENG_WE,
    input  logic [ADDR_W-1:0]      ENG_ADDR,
    input  logic [BE_W-1:0]        ENG_BYTE_EN,
    input  logic [DATA_W-1:0]      ENG_WDATA,
    output logic                   ENG_GNT,
    output logic                   ENG_RVALID,
    output logic [DATA_W-1:0]      ENG_RDATA,
    output logic [ADDR_W-1:0]      RAM_ADDR,
    output logic [BE_W-1:0]        RAM_BYTE_EN,
    output logic [DATA_W-1:0]      RAM_WDATA,
    output logic                   RAM_WREN,
    output logic                   RAM_RDEN,
    input  logic [DATA_W-1:0]      RAM_Q
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic              eng_rvalid_q;
    logic              eng_rvalid_d;
    logic [DATA_W-1:0] eng_rdata_q;
    logic [DATA_W-1:0] eng_rdata_d;

    logic cpu_req;
    logic pal_acc;
    logic in_idle;
    logic gnt_vld;
    gnt_t gnt_who;
    logic cpu_gnt;
    logic eng_gnt;
    logic cpu_done;

    assign cpu_req = AVL_CS & (AVL_READ | AVL_WRITE) & ~AVL_ADDR[PAL_SEL_BIT];
    assign pal_acc = AVL_CS & (AVL_READ | AVL_WRITE) &  AVL_ADDR[PAL_SEL_BIT];
    assign in_idle = (state_q == IDLE);

    // Grants are only issued from IDLE; the read data cycles block the port.
    rr_arb2 u_rr_arb2 (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .en_i      (in_idle),
        .req_cpu_i (cpu_req),
        .req_eng_i (ENG_REQ),
        .gnt_vld_o (gnt_vld),
        .gnt_o     (gnt_who)
    );

    assign cpu_gnt = gnt_vld & (gnt_who == GNT_CPU);
    assign eng_gnt = gnt_vld & (gnt_who == GNT_ENG);

    // State register and engine read-return registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            eng_rvalid_q <= 1'b0;
            eng_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            eng_rvalid_q <= eng_rvalid_d;
            eng_rdata_q  <= eng_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        eng_rvalid_d = 1'b0;
        eng_rdata_d  = eng_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_gnt && !AVL_WRITE) begin
                    state_d = CPU_RD;
                end else if (eng_gnt && !ENG_WE) begin
                    state_d = ENG_RD;
                end
            end
            CPU_RD: begin
                state_d = IDLE;
            end
            ENG_RD: begin
                // RAM_Q is valid now; present it to the engine next cycle.
                eng_rvalid_d = 1'b1;
                eng_rdata_d  = RAM_Q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        RAM_ADDR    = '0;
        RAM_BYTE_EN = '0;
        RAM_WDATA   = '0;
        RAM_WREN    = 1'b0;
        RAM_RDEN    = 1'b0;
        if (cpu_gnt) begin
            RAM_ADDR    = AVL_ADDR[ADDR_W-1:0];
            RAM_BYTE_EN = AVL_BYTE_EN;
            RAM_WDATA   = AVL_WRITEDATA;
            RAM_WREN    = AVL_WRITE;
            RAM_RDEN    = ~AVL_WRITE;
        end else if (eng_gnt) begin
            RAM_ADDR    = ENG_ADDR;
            RAM_BYTE_EN = ENG_BYTE_EN;
            RAM_WDATA   = ENG_WDATA;
            RAM_WREN    = ENG_WE;
            RAM_RDEN    = ~ENG_WE;
        end

        // The CPU completes on its write grant or in its read data cycle;
        // palette accesses never stall because cpu_req is low for them.
        cpu_done        = (cpu_gnt & AVL_WRITE) | (state_q == CPU_RD);
        AVL_WAITREQUEST = cpu_req & ~cpu_done;
        AVL_READDATA    = (state_q == CPU_RD) ? RAM_Q : '0;

        ENG_GNT    = eng_gnt;
        ENG_RVALID = eng_rvalid_q;
        ENG_RDATA  = eng_rdata_q;
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;

    logic        CLK;
    logic        RESET;
    logic        AVL_CS;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic [11:0] AVL_ADDR;
    logic [3:0]  AVL_BYTE_EN;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;
    logic        AVL_WAITREQUEST;
    logic        ENG_REQ;
    logic        ENG_WE;
    logic [10:0] ENG_ADDR;
    logic [3:0]  ENG_BYTE_EN;
    logic [31:0] ENG_WDATA;
    logic        ENG_GNT;
    logic        ENG_RVALID;
    logic [31:0] ENG_RDATA;
    logic [10:0] RAM_ADDR;
    logic [3:0]  RAM_BYTE_EN;
    logic [31:0] RAM_WDATA;
    logic        RAM_WREN;
    logic        RAM_RDEN;
    logic [31:0] RAM_Q;

    int total;
    int bad;

    vram_port_arbiter #(
        .ADDR_W (11),
        .DATA_W (32),
        .BE_W   (4)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .AVL_CS          (AVL_CS),
        .AVL_READ        (AVL_READ),
        .AVL_WRITE       (AVL_WRITE),
        .AVL_ADDR        (AVL_ADDR),
        .AVL_BYTE_EN     (AVL_BYTE_EN),
        .AVL_WRITEDATA   (AVL_WRITEDATA),
        .AVL_READDATA    (AVL_READDATA),
        .AVL_WAITREQUEST (AVL_WAITREQUEST),
        .ENG_REQ         (ENG_REQ),
        .ENG_WE          (ENG_WE),
        .ENG_ADDR        (ENG_ADDR),
        .ENG_BYTE_EN     (ENG_BYTE_EN),
        .ENG_WDATA       (ENG_WDATA),
        .ENG_GNT         (ENG_GNT),
        .ENG_RVALID      (ENG_RVALID),
        .ENG_RDATA       (ENG_RDATA),
        .RAM_ADDR        (RAM_ADDR),
        .RAM_BYTE_EN     (RAM_BYTE_EN),
        .RAM_WDATA       (RAM_WDATA),
        .RAM_WREN        (RAM_WREN),
        .RAM_RDEN        (RAM_RDEN),
        .RAM_Q           (RAM_Q)
    );

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    // Port-A RAM model: byte-enabled write, one-cycle registered read.
    logic [31:0] mem [0:2047];
    logic        pre_we;
    logic [10:0] pre_addr;
    logic [31:0] pre_data;

    always @(posedge CLK) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (RAM_WREN) begin
            for (int b = 0; b < 4; b++) begin
                if (RAM_BYTE_EN[b]) mem[RAM_ADDR][b*8 +: 8] <= RAM_WDATA[b*8 +: 8];
            end
        end
        if (RAM_RDEN) RAM_Q <= mem[RAM_ADDR];
    end

    typedef struct {
        logic        cs, rd, wr;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        ereq, ewe;
        logic [10:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic        x_wren, x_rden;
        logic [10:0] x_addr;
        logic [3:0]  x_be;
        logic [31:0] x_wd;
        logic        x_wait, x_gnt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        AVL_CS        = 1'b0;
        AVL_READ      = 1'b0;
        AVL_WRITE     = 1'b0;
        AVL_ADDR      = '0;
        AVL_BYTE_EN   = '0;
        AVL_WRITEDATA = '0;
        ENG_REQ       = 1'b0;
        ENG_WE        = 1'b0;
        ENG_ADDR      = '0;
        ENG_BYTE_EN   = '0;
        ENG_WDATA     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
        AVL_CS = 1'b1; AVL_READ = 1'b0; AVL_WRITE = 1'b1;
        AVL_ADDR = a; AVL_BYTE_EN = 4'hF; AVL_WRITEDATA = d;
    endtask

    task automatic cpu_read(input logic [11:0] a, input logic [31:0] exp, input string nm);
        next_cycle();
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0;
        AVL_ADDR = a; AVL_BYTE_EN = 4'hF; AVL_WRITEDATA = '0;
        @(negedge CLK);
        chk({nm, "_c0_rden"}, 32'(RAM_RDEN), 32'd1);
        chk({nm, "_c0_wait"}, 32'(AVL_WAITREQUEST), 32'd1);
        chk({nm, "_c0_addr"}, 32'(RAM_ADDR), 32'(a[10:0]));
        next_cycle();
        @(negedge CLK);
        chk({nm, "_c1_wait"}, 32'(AVL_WAITREQUEST), 32'd0);
        chk({nm, "_c1_rdata"}, AVL_READDATA, exp);
        chk({nm, "_c1_rden"}, 32'(RAM_RDEN), 32'd0);
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;

        //            cs rd wr addr     be    wd            ereq ewe eaddr   ebe   ewd            wren rden addr    be    wd            wait gnt
        vecs[0]  = '{1, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF, 0, 0, 11'h000, 4'h0, 32'h00000000, 1, 0, 11'h010, 4'hF, 32'hDEADBEEF, 0, 0};
        vecs[1]  = '{1, 0, 1, 12'h011, 4'hF, 32'h11111111, 1, 1, 11'h100, 4'h3, 32'hAAAA5555, 1, 0, 11'h100, 4'h3, 32'hAAAA5555, 1, 1};
        vecs[2]  = '{1, 0, 1, 12'h011, 4'hF, 32'h11111111, 1, 1, 11'h100, 4'h3, 32'hAAAA5555, 1, 0, 11'h011, 4'hF, 32'h11111111, 0, 0};
        vecs[3]  = '{1, 0, 1, 12'h011, 4'hF, 32'h11111111, 1, 1, 11'h100, 4'h3, 32'hAAAA5555, 1, 0, 11'h100, 4'h3, 32'hAAAA5555, 1, 1};
        vecs[4]  = '{1, 0, 1, 12'h803, 4'hF, 32'h12345678, 0, 0, 11'h000, 4'h0, 32'h00000000, 0, 0, 11'h000, 4'h0, 32'h00000000, 0, 0};
        vecs[5]  = '{1, 1, 0, 12'h805, 4'hF, 32'h00000000, 0, 0, 11'h000, 4'h0, 32'h00000000, 0, 0, 11'h000, 4'h0, 32'h00000000, 0, 0};
        vecs[6]  = '{0, 0, 0, 12'h000, 4'h0, 32'h00000000, 0, 0, 11'h000, 4'h0, 32'h00000000, 0, 0, 11'h000, 4'h0, 32'h00000000, 0, 0};
        vecs[7]  = '{1, 0, 1, 12'h012, 4'h0, 32'h00000055, 0, 0, 11'h000, 4'h0, 32'h00000000, 1, 0, 11'h012, 4'h0, 32'h00000055, 0, 0};
        vecs[8]  = '{0, 0, 0, 12'h000, 4'h0, 32'h00000000, 1, 1, 11'h7FF, 4'h8, 32'hCAFEF00D, 1, 0, 11'h7FF, 4'h8, 32'hCAFEF00D, 0, 1};
        vecs[9]  = '{0, 0, 1, 12'h013, 4'hF, 32'h77777777, 0, 0, 11'h000, 4'h0, 32'h00000000, 0, 0, 11'h000, 4'h0, 32'h00000000, 0, 0};
        vecs[10] = '{1, 0, 1, 12'h8FF, 4'hF, 32'h66666666, 1, 1, 11'h101, 4'hF, 32'h01010101, 1, 0, 11'h101, 4'hF, 32'h01010101, 0, 1};
        vecs[11] = '{1, 0, 1, 12'h014, 4'hF, 32'h14141414, 1, 1, 11'h102, 4'hF, 32'h02020202, 1, 0, 11'h014, 4'hF, 32'h14141414, 0, 0};

        // Reset with RAM preload behind it.
        idle_inputs();
        RESET = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            pre_we = 1'b1;
            case (i)
                0: begin pre_addr = 11'h020; pre_data = 32'h12345678; end
                1: begin pre_addr = 11'h3FF; pre_data = 32'h0BADC0DE; end
                2: begin pre_addr = 11'h100; pre_data = 32'h11223344; end
                3: begin pre_addr = 11'h7FF; pre_data = 32'h55667788; end
                default: begin pre_addr = 11'h012; pre_data = 32'h99AABBCC; end
            endcase
            next_cycle();
        end
        pre_we = 1'b0;
        @(negedge CLK);
        chk("rst_wren",  32'(RAM_WREN), 32'd0);
        chk("rst_rden",  32'(RAM_RDEN), 32'd0);
        chk("rst_gnt",   32'(ENG_GNT), 32'd0);
        chk("rst_rvalid", 32'(ENG_RVALID), 32'd0);
        chk("rst_rdata", ENG_RDATA, 32'd0);
        chk("rst_wait",  32'(AVL_WAITREQUEST), 32'd0);
        chk("rst_rdout", AVL_READDATA, 32'd0);
        next_cycle();
        RESET = 1'b0;

        // Single-cycle write / palette / idle vectors from reset (last_gnt=ENG).
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            AVL_CS = vecs[i].cs; AVL_READ = vecs[i].rd; AVL_WRITE = vecs[i].wr;
            AVL_ADDR = vecs[i].addr; AVL_BYTE_EN = vecs[i].be; AVL_WRITEDATA = vecs[i].wd;
            ENG_REQ = vecs[i].ereq; ENG_WE = vecs[i].ewe; ENG_ADDR = vecs[i].eaddr;
            ENG_BYTE_EN = vecs[i].ebe; ENG_WDATA = vecs[i].ewd;
            @(negedge CLK);
            chk($sformatf("v%0d_wren", i),  32'(RAM_WREN), 32'(vecs[i].x_wren));
            chk($sformatf("v%0d_rden", i),  32'(RAM_RDEN), 32'(vecs[i].x_rden));
            chk($sformatf("v%0d_addr", i),  32'(RAM_ADDR), 32'(vecs[i].x_addr));
            chk($sformatf("v%0d_be", i),    32'(RAM_BYTE_EN), 32'(vecs[i].x_be));
            chk($sformatf("v%0d_wdata", i), RAM_WDATA, vecs[i].x_wd);
            chk($sformatf("v%0d_wait", i),  32'(AVL_WAITREQUEST), 32'(vecs[i].x_wait));
            chk($sformatf("v%0d_gnt", i),   32'(ENG_GNT), 32'(vecs[i].x_gnt));
            chk($sformatf("v%0d_rdout", i), AVL_READDATA, 32'd0);
        end
        next_cycle();
        idle_inputs();

        // Readbacks: preloaded word, plain writes, byte-enable merges.
        cpu_read(12'h020, 32'h12345678, "rd020");
        cpu_read(12'h010, 32'hDEADBEEF, "rd010");
        cpu_read(12'h011, 32'h11111111, "rd011");
        cpu_read(12'h100, 32'h11225555, "rd100_be3");
        cpu_read(12'h7FF, 32'hCA667788, "rd7FF_be8");
        cpu_read(12'h012, 32'h99AABBCC, "rd012_be0");
        cpu_read(12'h101, 32'h01010101, "rd101");
        cpu_read(12'h014, 32'h14141414, "rd014");

        // Both sides writing continuously from reset: strict alternation.
        do_reset();
        cpu_write(12'h040, 32'hC0C0C0C0);
        ENG_REQ = 1'b1; ENG_WE = 1'b1; ENG_ADDR = 11'h041; ENG_BYTE_EN = 4'hF; ENG_WDATA = 32'hE0E0E0E0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("alt%0d_wren", i), 32'(RAM_WREN), 32'd1);
            chk($sformatf("alt%0d_gnt", i),  32'(ENG_GNT), 32'(i % 2));
            chk($sformatf("alt%0d_wait", i), 32'(AVL_WAITREQUEST), 32'(i % 2));
            chk($sformatf("alt%0d_addr", i), 32'(RAM_ADDR), (i % 2 == 0) ? 32'h040 : 32'h041);
            next_cycle();
        end
        idle_inputs();

        // Engine read of 0x3FF contending with a CPU write.
        do_reset();
        cpu_write(12'h030, 32'h01020304);
        ENG_REQ = 1'b1; ENG_WE = 1'b0; ENG_ADDR = 11'h3FF; ENG_BYTE_EN = 4'hF; ENG_WDATA = '0;
        @(negedge CLK);
        chk("er_c0_wren", 32'(RAM_WREN), 32'd1);
        chk("er_c0_addr", 32'(RAM_ADDR), 32'h030);
        chk("er_c0_gnt",  32'(ENG_GNT), 32'd0);
        chk("er_c0_wait", 32'(AVL_WAITREQUEST), 32'd0);
        next_cycle();
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
        @(negedge CLK);
        chk("er_c1_gnt",  32'(ENG_GNT), 32'd1);
        chk("er_c1_rden", 32'(RAM_RDEN), 32'd1);
        chk("er_c1_addr", 32'(RAM_ADDR), 32'h3FF);
        next_cycle();
        ENG_REQ = 1'b0;
        cpu_write(12'h031, 32'h0A0B0C0D);
        @(negedge CLK);
        chk("er_c2_wait",   32'(AVL_WAITREQUEST), 32'd1);
        chk("er_c2_wren",   32'(RAM_WREN), 32'd0);
        chk("er_c2_rvalid", 32'(ENG_RVALID), 32'd0);
        next_cycle();
        @(negedge CLK);
        chk("er_c3_rvalid", 32'(ENG_RVALID), 32'd1);
        chk("er_c3_rdata",  ENG_RDATA, 32'h0BADC0DE);
        chk("er_c3_wren",   32'(RAM_WREN), 32'd1);
        chk("er_c3_addr",   32'(RAM_ADDR), 32'h031);
        chk("er_c3_wait",   32'(AVL_WAITREQUEST), 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        chk("er_c4_rvalid", 32'(ENG_RVALID), 32'd0);
        cpu_read(12'h030, 32'h01020304, "rd030");

        // Reset during the engine read data cycle.
        do_reset();
        ENG_REQ = 1'b1; ENG_WE = 1'b0; ENG_ADDR = 11'h3FF; ENG_BYTE_EN = 4'hF;
        @(negedge CLK);
        chk("rr_c0_gnt",  32'(ENG_GNT), 32'd1);
        chk("rr_c0_rden", 32'(RAM_RDEN), 32'd1);
        next_cycle();
        ENG_REQ = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        chk("rr_c1_rvalid", 32'(ENG_RVALID), 32'd0);
        next_cycle();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rr_c2_rvalid", 32'(ENG_RVALID), 32'd0);
        chk("rr_c2_rdata",  ENG_RDATA, 32'd0);
        next_cycle();
        cpu_write(12'h050, 32'h50505050);
        ENG_REQ = 1'b1; ENG_WE = 1'b1; ENG_ADDR = 11'h051; ENG_BYTE_EN = 4'hF; ENG_WDATA = 32'h51515151;
        @(negedge CLK);
        chk("rr_c3_wren", 32'(RAM_WREN), 32'd1);
        chk("rr_c3_gnt",  32'(ENG_GNT), 32'd0);
        chk("rr_c3_addr", 32'(RAM_ADDR), 32'h050);
        next_cycle();
        idle_inputs();
        cpu_read(12'h3FF, 32'h0BADC0DE, "rd3FF");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
